// File: rtl/b32p_isa_pkg.sv
// rtl/b32p_isa_pkg.sv - B32P instruction formats, field positions and constant range limits
package b32p_isa_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_A = 3'd1;
    localparam logic [2:0] FMT_C = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_L = 3'd5;

    localparam int OP_LSB   = 28;
    localparam int ALU_LSB  = 24;
    localparam int CA_LSB   = 8;   // A-format constant sits in [23:8]
    localparam int CC_LSB   = 12;  // C/B/L-format constant sits in [27:12]
    localparam int CJ_LSB   = 1;
    localparam int AREG_LSB = 8;
    localparam int BREG_LSB = 4;
    localparam int DREG_LSB = 0;
    localparam int BOP_LSB  = 1;
    localparam int HE_BIT   = 8;

    // Lowest bit of the constant that must be a pure sign/zero extension
    localparam int C16_SIGN_LSB = 15;
    localparam int L16_ZERO_LSB = 16;
    localparam int J_SIGN_LSB   = 26;
    localparam int J_ZERO_LSB   = 27;

    function automatic logic uniform_from(input logic [31:0] v, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++)
            if (i >= lsb && v[i] != v[31]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic zero_from(input logic [31:0] v, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++)
            if (i >= lsb && v[i]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational field pack and constant range check for one instruction
module instr_field_pack
    import b32p_isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [3:0]  instr_op,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  branch_op,
    input  logic [31:0] cnst,
    input  logic [3:0]  areg,
    input  logic [3:0]  breg,
    input  logic [3:0]  dreg,
    input  logic        he,
    input  logic        oe,
    input  logic        sig,
    output logic [31:0] word,
    output logic        err
);

    always_comb begin
        word = '0;
        err  = 1'b0;
        word[OP_LSB +: 4] = instr_op;
        case (fmt)
            FMT_R: begin
                word[ALU_LSB  +: 4] = alu_op;
                word[AREG_LSB +: 4] = areg;
                word[BREG_LSB +: 4] = breg;
                word[DREG_LSB +: 4] = dreg;
            end
            FMT_A: begin
                word[ALU_LSB  +: 4]  = alu_op;
                word[CA_LSB   +: 16] = cnst[15:0];
                word[BREG_LSB +: 4]  = breg;
                word[DREG_LSB +: 4]  = dreg;
                err = !uniform_from(cnst, C16_SIGN_LSB);
            end
            FMT_C: begin
                word[CC_LSB   +: 16] = cnst[15:0];
                word[AREG_LSB +: 4]  = areg;
                word[BREG_LSB +: 4]  = breg;
                word[DREG_LSB +: 4]  = dreg;
                err = !uniform_from(cnst, C16_SIGN_LSB);
            end
            FMT_B: begin
                word[CC_LSB   +: 16] = cnst[15:0];
                word[AREG_LSB +: 4]  = areg;
                word[BREG_LSB +: 4]  = breg;
                word[BOP_LSB  +: 3]  = branch_op;
                word[0]              = sig;
                err = !uniform_from(cnst, C16_SIGN_LSB);
            end
            FMT_J: begin
                word[CJ_LSB +: 27] = cnst[26:0];
                word[0]            = oe;
                // Offset jumps are signed 27-bit, absolute jumps unsigned 27-bit
                err = oe ? !uniform_from(cnst, J_SIGN_LSB) : !zero_from(cnst, J_ZERO_LSB);
            end
            FMT_L: begin
                word[CC_LSB   +: 16] = cnst[15:0];
                word[HE_BIT]         = he;
                word[DREG_LSB +: 4]  = dreg;
                err = !zero_from(cnst, L16_ZERO_LSB);
            end
            default: begin
                word = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_word_encoder.sv
// rtl/instr_word_encoder.sv - field-set to instruction-word stream encoder; optional ENCODER_SELFCHECK_EN re-decode checker
module instr_word_encoder
    import b32p_isa_pkg::*;
#(
    parameter int                ADDR_W     = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                OBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [3:0]        in_instrOP,
    input  logic [3:0]        in_aluOP,
    input  logic [2:0]        in_branchOP,
    input  logic [31:0]       in_const,
    input  logic [3:0]        in_areg,
    input  logic [3:0]        in_breg,
    input  logic [3:0]        in_dreg,
    input  logic              in_he,
    input  logic              in_oe,
    input  logic              in_sig,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              restart,
    input  logic              err_clr,
    output logic              err_range,
    output logic [7:0]        err_cnt,
    output logic              err_selfchk
);

    localparam int             PW       = $clog2(OBUF_DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(OBUF_DEPTH);

    logic [31:0]   mem [OBUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [31:0]   pack_word;
    logic          pack_err;
    logic          accept, push, pop, bad;

    instr_field_pack u_pack (
        .fmt       (in_fmt),
        .instr_op  (in_instrOP),
        .alu_op    (in_aluOP),
        .branch_op (in_branchOP),
        .cnst      (in_const),
        .areg      (in_areg),
        .breg      (in_breg),
        .dreg      (in_dreg),
        .he        (in_he),
        .oe        (in_oe),
        .sig       (in_sig),
        .word      (pack_word),
        .err       (pack_err)
    );

    // Ready depends only on the registered fill level, never on out_ready
    assign in_ready  = (count != FULL_CNT) && !restart;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !pack_err;
    assign bad       = accept && pack_err;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= BASE_ADDR;
            for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
        end else if (restart) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= BASE_ADDR;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pack_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_addr <= out_addr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_range <= 1'b0;
            err_cnt   <= '0;
        end else if (bad) begin
            err_range <= 1'b1;
            if (err_clr)               err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (err_clr) begin
            err_range <= 1'b0;
            err_cnt   <= '0;
        end
    end

`ifdef ENCODER_SELFCHECK_EN
    logic chk_bad;

    always_comb begin
        chk_bad = (pack_word[OP_LSB +: 4] != in_instrOP);
        case (in_fmt)
            FMT_R: chk_bad = chk_bad | (pack_word[ALU_LSB +: 4] != in_aluOP)
                           | (pack_word[AREG_LSB +: 4] != in_areg) | (pack_word[BREG_LSB +: 4] != in_breg)
                           | (pack_word[DREG_LSB +: 4] != in_dreg);
            FMT_A: chk_bad = chk_bad | (pack_word[ALU_LSB +: 4] != in_aluOP)
                           | (pack_word[CA_LSB +: 16] != in_const[15:0])
                           | (pack_word[BREG_LSB +: 4] != in_breg) | (pack_word[DREG_LSB +: 4] != in_dreg);
            FMT_C: chk_bad = chk_bad | (pack_word[CC_LSB +: 16] != in_const[15:0])
                           | (pack_word[AREG_LSB +: 4] != in_areg) | (pack_word[BREG_LSB +: 4] != in_breg)
                           | (pack_word[DREG_LSB +: 4] != in_dreg);
            FMT_B: chk_bad = chk_bad | (pack_word[CC_LSB +: 16] != in_const[15:0])
                           | (pack_word[AREG_LSB +: 4] != in_areg) | (pack_word[BREG_LSB +: 4] != in_breg)
                           | (pack_word[BOP_LSB +: 3] != in_branchOP) | (pack_word[0] != in_sig);
            FMT_J: chk_bad = chk_bad | (pack_word[CJ_LSB +: 27] != in_const[26:0]) | (pack_word[0] != in_oe);
            FMT_L: chk_bad = chk_bad | (pack_word[CC_LSB +: 16] != in_const[15:0])
                           | (pack_word[HE_BIT] != in_he) | (pack_word[DREG_LSB +: 4] != in_dreg);
            default: chk_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              err_selfchk <= 1'b0;
        else if (push && chk_bad)  err_selfchk <= 1'b1;
        else if (err_clr)          err_selfchk <= 1'b0;
    end
`else
    assign err_selfchk = 1'b0;
`endif

endmodule

// File: tb/tb_instr_word_encoder.sv
// tb/tb_instr_word_encoder.sv - scoreboard bench for instr_word_encoder
module tb_instr_word_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [3:0]  in_instrOP, in_aluOP;
    logic [2:0]  in_branchOP;
    logic [31:0] in_const;
    logic [3:0]  in_areg, in_breg, in_dreg;
    logic        in_he, in_oe, in_sig;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic [26:0] out_addr;
    logic        restart, err_clr, err_range, err_selfchk;
    logic [7:0]  err_cnt;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] sb_q[$];
    logic [26:0] tb_addr = '0;

    always #5 clk = ~clk;

    instr_word_encoder dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_instrOP(in_instrOP), .in_aluOP(in_aluOP), .in_branchOP(in_branchOP),
        .in_const(in_const), .in_areg(in_areg), .in_breg(in_breg), .in_dreg(in_dreg),
        .in_he(in_he), .in_oe(in_oe), .in_sig(in_sig),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .restart(restart), .err_clr(err_clr), .err_range(err_range), .err_cnt(err_cnt),
        .err_selfchk(err_selfchk)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so the negedge sees the values of the next edge
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                chk("out_instr", 64'(out_instr), 64'(sb_q.pop_front()));
                chk("out_addr", 64'(out_addr), 64'(tb_addr));
                tb_addr = tb_addr + 1'b1;
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [3:0] op, input logic [3:0] alu,
                        input logic [2:0] bop, input logic [31:0] c, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] d, input logic he, input logic oe,
                        input logic sig, input logic [31:0] exp_word, input logic exp_err);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_fmt = fmt; in_instrOP = op; in_aluOP = alu; in_branchOP = bop; in_const = c;
        in_areg = a; in_breg = b; in_dreg = d; in_he = he; in_oe = oe; in_sig = sig;
        in_valid = 1'b1;
        if (!exp_err) sb_q.push_back(exp_word);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        #1 chk("restart_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        restart = 1'b0;
        sb_q.delete();
        tb_addr = '0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; restart = 1'b0; err_clr = 1'b0;
        in_fmt = '0; in_instrOP = '0; in_aluOP = '0; in_branchOP = '0; in_const = '0;
        in_areg = '0; in_breg = '0; in_dreg = '0; in_he = 1'b0; in_oe = 1'b0; in_sig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_err_range", 64'(err_range), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        reset_n = 1'b1;
        out_ready = 1'b1;

        // Format coverage with hand-packed words
        send(3'd0, 4'd0, 4'd2, 3'd0, 32'd0, 4'd3, 4'd5, 4'd7, 0, 0, 0, 32'h0200_0357, 0);
        chk("latency_one_cycle", 64'(out_valid), 64'd1);
        send(3'd1, 4'd1, 4'd0, 3'd0, 32'hFFFF_FFFF, 4'd0, 4'd2, 4'd1, 0, 0, 0, 32'h10FF_FF21, 0);
        send(3'd3, 4'd6, 4'd0, 3'b010, 32'hFFFF_FFFC, 4'd1, 4'd2, 4'd0, 0, 0, 1, 32'h6FFF_C125, 0);
        send(3'd4, 4'd9, 4'd0, 3'd0, 32'h0000_0100, 4'd0, 4'd0, 4'd0, 0, 1, 0, 32'h9000_0201, 0);
        send(3'd2, 4'd2, 4'd0, 3'd0, 32'h0000_1234, 4'd4, 4'd5, 4'd6, 0, 0, 0, 32'h2123_4456, 0);
        send(3'd5, 4'd7, 4'd0, 3'd0, 32'h0000_ABCD, 4'd0, 4'd0, 4'd3, 1, 0, 0, 32'h7ABC_D103, 0);
        send(3'd1, 4'd1, 4'd3, 3'd0, 32'h0000_7FFF, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h137F_FF00, 0);
        send(3'd1, 4'd1, 4'd3, 3'd0, 32'hFFFF_8000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h1380_0000, 0);
        send(3'd4, 4'd9, 4'd0, 3'd0, 32'h07FF_FFFF, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h9FFF_FFFE, 0);
        drain();

        // Range errors: consumed without a word, address not advanced
        send(3'd1, 4'd1, 4'd0, 3'd0, 32'h0000_8000, 4'd0, 4'd2, 4'd1, 0, 0, 0, 32'h0, 1);
        chk("err_no_word", 64'(out_valid), 64'd0);
        chk("err_range_set", 64'(err_range), 64'd1);
        chk("err_cnt_1", 64'(err_cnt), 64'd1);
        send(3'd0, 4'd0, 4'd2, 3'd0, 32'd0, 4'd3, 4'd5, 4'd7, 0, 0, 0, 32'h0200_0357, 0);
        drain();
        send(3'd6, 4'd0, 4'd0, 3'd0, 32'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        send(3'd4, 4'd9, 4'd0, 3'd0, 32'h0800_0000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        send(3'd4, 4'd9, 4'd0, 3'd0, 32'h0400_0000, 4'd0, 4'd0, 4'd0, 0, 1, 0, 32'h0, 1);
        send(3'd5, 4'd7, 4'd0, 3'd0, 32'h0001_0000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        send(3'd3, 4'd6, 4'd0, 3'd0, 32'hFFFF_7FFF, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        chk("err_cnt_6", 64'(err_cnt), 64'd6);
        chk("err_only_no_word", 64'(out_valid), 64'd0);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("clr_range", 64'(err_range), 64'd0);
        chk("clr_cnt", 64'(err_cnt), 64'd0);

        // err_clr coinciding with a new error: error wins
        send(3'd1, 4'd1, 4'd0, 3'd0, 32'h0000_8000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        err_clr = 1'b1;
        send(3'd7, 4'd0, 4'd0, 3'd0, 32'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        err_clr = 1'b0;
        chk("clr_vs_err_range", 64'(err_range), 64'd1);
        chk("clr_vs_err_cnt", 64'(err_cnt), 64'd1);

        for (int i = 0; i < 300; i++)
            send(3'd6, 4'd0, 4'd0, 3'd0, 32'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        chk("err_cnt_saturate", 64'(err_cnt), 64'd255);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

        // Backpressure: buffer of two fills, third waits
        pulse_restart();
        out_ready = 1'b0;
        send(3'd0, 4'd1, 4'd1, 3'd0, 32'd0, 4'd1, 4'd1, 4'd1, 0, 0, 0, 32'h1100_0111, 0);
        send(3'd0, 4'd2, 4'd2, 3'd0, 32'd0, 4'd2, 4'd2, 4'd2, 0, 0, 0, 32'h2200_0222, 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_instr", 64'(out_instr), 64'h1100_0111);
        chk("stall_addr", 64'(out_addr), 64'd0);
        out_ready = 1'b1;
        send(3'd0, 4'd3, 4'd3, 3'd0, 32'd0, 4'd3, 4'd3, 4'd3, 0, 0, 0, 32'h3300_0333, 0);
        drain();

        // Restart flushes buffered words and rewinds the address
        out_ready = 1'b0;
        send(3'd2, 4'd2, 4'd0, 3'd0, 32'h0000_0001, 4'd1, 4'd1, 4'd1, 0, 0, 0, 32'h2000_1111, 0);
        send(3'd2, 4'd2, 4'd0, 3'd0, 32'h0000_0002, 4'd2, 4'd2, 4'd2, 0, 0, 0, 32'h2000_2222, 0);
        pulse_restart();
        chk("restart_flush", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(3'd2, 4'd2, 4'd0, 3'd0, 32'h0000_0003, 4'd3, 4'd3, 4'd3, 0, 0, 0, 32'h2000_3333, 0);
        drain();

        // Reset mid-stream
        out_ready = 1'b0;
        send(3'd0, 4'd5, 4'd5, 3'd0, 32'd0, 4'd5, 4'd5, 4'd5, 0, 0, 0, 32'h5500_0555, 0);
        send(3'd1, 4'd1, 4'd0, 3'd0, 32'h0001_0000, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_instr", 64'(out_instr), 64'd0);
        chk("midrst_out_addr", 64'(out_addr), 64'd0);
        chk("midrst_err_range", 64'(err_range), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
        sb_q.delete();
        tb_addr = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(3'd5, 4'd7, 4'd0, 3'd0, 32'h0000_0042, 4'd0, 4'd0, 4'd9, 0, 0, 0, 32'h7004_2009, 0);
        drain();
        chk("selfchk_clean", 64'(err_selfchk), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
